// File: rtl/mcav_core_mc.sv
// mcav_core_mc: multi-cycle 9-bit-ISA processor core.
// Contains the four-entry register file, ALU, Z/C flags, PC and a run-cycle
// counter. Instruction ROM and data memory sit outside the core. Both have a
// one-cycle synchronous read.
//
// Run handshake (req/done): req is sampled only in IDLE and DONE. A high req
// in either state starts a run at the next clock. done is a level that is high
// for as long as the core sits in DONE. In DONE, a new req restarts the run
// from pc=0 and keeps the register file and flags. req in any other state has
// no effect.
module mcav_core_mc #(
   parameter int W       = 8,
   parameter int D       = 12,
   parameter int HALT_PC = 128,
   parameter int CW      = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   output logic          done,
   output logic [D-1:0]  imem_addr,
   input  logic [8:0]    imem_dat,
   output logic [W-1:0]  dmem_addr,
   output logic [W-1:0]  dmem_wdat,
   output logic          dmem_we,
   input  logic [W-1:0]  dmem_rdat,
   output logic [CW-1:0] cycles,
   output logic          zero_flag,
   output logic          carry_flag
);

   // Explicit encodings so that checkers can compare the state directly.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   // The branch offset is 5 bits. When D is narrower, the sum is formed at
   // 5 bits and truncated, which keeps the wrap modulo 2^D.
   localparam int TW = (D > 5) ? D : 5;

   state_t            state_q, state_d;
   logic [D-1:0]      pc_q, pc_d;
   logic [3:0][W-1:0] rf_q, rf_d;
   logic [8:0]        ir_q, ir_d;
   logic              z_q, z_d;
   logic              c_q, c_d;
   logic [CW-1:0]     cycles_q, cycles_d;

   logic [1:0]        rd_idx, rs_idx;
   logic [W-1:0]      rd_v, rs_v;
   logic [W:0]        sum_w, diff_w;
   logic [W-1:0]      alu_res;
   logic              alu_c;
   logic [W-1:0]      ldi_val;
   logic [D-1:0]      pc_inc;
   logic [TW-1:0]     pc_ext, off_ext, tgt_full;
   logic [D-1:0]      target;

   assign rd_idx  = ir_q[3:2];
   assign rs_idx  = ir_q[1:0];
   assign rd_v    = rf_q[rd_idx];
   assign rs_v    = rf_q[rs_idx];
   assign ldi_val = W'(ir_q[4:0]);
   assign pc_inc  = pc_q + D'(1);

   // Relative branch target: the PC of the branch plus the sign-extended offset.
   always_comb begin
      pc_ext   = TW'(pc_q);
      off_ext  = TW'($signed(ir_q[4:0]));
      tgt_full = pc_ext + off_ext;
      target   = tgt_full[D-1:0];
   end

   // ALU result and carry for the op held in IR. Only EXEC consumes them.
   always_comb begin
      sum_w   = {1'b0, rd_v} + {1'b0, rs_v};
      diff_w  = {1'b0, rd_v} - {1'b0, rs_v};
      alu_res = rd_v;
      alu_c   = c_q;
      case (ir_q[6:4])
         3'd0: begin alu_res = sum_w[W-1:0];  alu_c = sum_w[W];  end
         3'd1: begin alu_res = diff_w[W-1:0]; alu_c = diff_w[W]; end
         3'd2: alu_res = rd_v & rs_v;
         3'd3: alu_res = rd_v | rs_v;
         3'd4: alu_res = rd_v ^ rs_v;
         3'd5: begin alu_res = {rd_v[W-2:0], c_q}; alu_c = rd_v[W-1]; end
         3'd6: begin alu_res = {c_q, rd_v[W-1:1]}; alu_c = rd_v[0];   end
         3'd7: alu_res = rs_v;
         default: alu_res = rd_v;
      endcase
   end

   // Next-state logic, architectural updates and the data-memory strobes for the FSM.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      rf_d      = rf_q;
      ir_d      = ir_q;
      z_d       = z_q;
      c_d       = c_q;
      cycles_d  = cycles_q;
      dmem_addr = '0;
      dmem_wdat = '0;
      dmem_we   = 1'b0;

      if ((state_q == S_FETCH || state_q == S_DECODE ||
           state_q == S_EXEC  || state_q == S_MEM) && (cycles_q != {CW{1'b1}}))
         cycles_d = cycles_q + CW'(1);

      case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d  = S_FETCH;
               cycles_d = '0;
            end
         end
         S_FETCH: begin
            if (pc_q == D'(HALT_PC)) state_d = S_DONE;
            else                     state_d = S_DECODE;
         end
         S_DECODE: begin
            ir_d    = imem_dat;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pc_inc;
            case (ir_q[8:7])
               2'b00: begin
                  rf_d[rd_idx] = alu_res;
                  c_d          = alu_c;
                  z_d          = (alu_res == '0);
               end
               2'b01: begin
                  rf_d[ir_q[6:5]] = ldi_val;
                  z_d             = (ldi_val == '0);
               end
               2'b10: begin
                  dmem_addr = rs_v;
                  if (ir_q[6]) begin
                     dmem_wdat = rd_v;
                     dmem_we   = 1'b1;
                  end else begin
                     // The load completes in MEM. The PC advances there.
                     pc_d    = pc_q;
                     state_d = S_MEM;
                  end
               end
               default: begin
                  case (ir_q[6:5])
                     2'b00: if (z_q)  pc_d = target;
                     2'b01: if (!z_q) pc_d = target;
                     2'b10: pc_d = target;
                     default: begin
                        pc_d    = pc_q;
                        state_d = S_DONE;
                     end
                  endcase
               end
            endcase
         end
         S_MEM: begin
            rf_d[rd_idx] = dmem_rdat;
            z_d          = (dmem_rdat == '0);
            pc_d         = pc_inc;
            state_d      = S_FETCH;
         end
         S_DONE: begin
            if (req) begin
               state_d  = S_FETCH;
               pc_d     = '0;
               cycles_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and architectural registers. Synchronous reset has priority over everything else.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         rf_q     <= '0;
         ir_q     <= '0;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         cycles_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rf_q     <= rf_d;
         ir_q     <= ir_d;
         z_q      <= z_d;
         c_q      <= c_d;
         cycles_q <= cycles_d;
      end
   end

   assign imem_addr  = pc_q;
   assign done       = (state_q == S_DONE);
   assign cycles     = cycles_q;
   assign zero_flag  = z_q;
   assign carry_flag = c_q;

endmodule
